// File: rtl/dut_step_ctrl.sv
// rtl/dut_step_ctrl.sv - DUT clock-enable / readback step sequencer
//
// Purpose:
//   Each accepted H2C packet enables the gated DUT clock for N cycles
//   (N = max(cfg_step_cycles, 1)). The block then optionally fires a one-cycle
//   C2H capture and waits for the C2H engine to finish before it re-opens H2C.
//
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   cfg_step_cycles   DUT cycles per packet, sampled on an accepted packet
//   cfg_capture_en    capture after the step (1) or skip it (0)
//   h2c_pkt_done      pulse: vip2dut fully loaded
//   c2h_done          pulse: capture transfer and CMPT finished
//   h2c_en            H2C may accept the next packet
//   dut_clk_en        CE for the DUT BUFGCE
//   c2h_capture       one-cycle pulse to latch dut2vip
//   busy              sequencer not idle
//   step_count        DUT cycles enabled since reset (wraps)
//   pkt_count         packets accepted since reset (wraps)
//   err_overrun       sticky: packet arrived while not idle

module dut_step_ctrl #(
  parameter int CNT_WIDTH  = 16,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CNT_WIDTH-1:0]  cfg_step_cycles,
  input  logic                  cfg_capture_en,
  input  logic                  h2c_pkt_done,
  input  logic                  c2h_done,
  output logic                  h2c_en,
  output logic                  dut_clk_en,
  output logic                  c2h_capture,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] step_count,
  output logic [STAT_WIDTH-1:0] pkt_count,
  output logic                  err_overrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    CAPT     = 2'd2,
    WAIT_C2H = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = '0;
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] cyc_cnt;
  logic                 capture_flag;
  logic                 accept;

  // A packet is only accepted in IDLE; anything else is an overrun.
  assign accept = (state == IDLE) && h2c_pkt_done;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (h2c_pkt_done) state_nxt = RUN;
      RUN:      if (cyc_cnt == CNT_ONE) state_nxt = capture_flag ? CAPT : IDLE;
      CAPT:     state_nxt = WAIT_C2H;
      WAIT_C2H: if (c2h_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs decoded purely from the registered state, so no input reaches
  // the BUFGCE CE or the control ports combinationally.
  always_comb begin
    h2c_en      = 1'b0;
    dut_clk_en  = 1'b0;
    c2h_capture = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        h2c_en = 1'b1;
        busy   = 1'b0;
      end
      RUN:      dut_clk_en  = 1'b1;
      CAPT:     c2h_capture = 1'b1;
      default: ;
    endcase
  end

  // Step counter, latched config and status counters. The step length and
  // capture flag are captured once per packet, so config edits mid-step are
  // only seen by the next packet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt      <= '0;
      capture_flag <= 1'b0;
      step_count   <= '0;
      pkt_count    <= '0;
      err_overrun  <= 1'b0;
    end else begin
      if (accept) begin
        cyc_cnt      <= (cfg_step_cycles == CNT_ZERO) ? CNT_ONE : cfg_step_cycles;
        capture_flag <= cfg_capture_en;
        pkt_count    <= pkt_count + STAT_ONE;
      end else if (state == RUN) begin
        cyc_cnt    <= cyc_cnt - CNT_ONE;
        step_count <= step_count + STAT_ONE;
      end
      if (h2c_pkt_done && (state != IDLE)) begin
        err_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dut_step_ctrl.sv
// tb/tb_dut_step_ctrl.sv - directed self-checking bench for dut_step_ctrl

module tb_dut_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_step_cycles;
  logic        cfg_capture_en;
  logic        h2c_pkt_done;
  logic        c2h_done;
  logic        h2c_en;
  logic        dut_clk_en;
  logic        c2h_capture;
  logic        busy;
  logic [31:0] step_count;
  logic [31:0] pkt_count;
  logic        err_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dut_step_ctrl #(.CNT_WIDTH(16), .STAT_WIDTH(32)) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_step_cycles (cfg_step_cycles),
    .cfg_capture_en  (cfg_capture_en),
    .h2c_pkt_done    (h2c_pkt_done),
    .c2h_done        (c2h_done),
    .h2c_en          (h2c_en),
    .dut_clk_en      (dut_clk_en),
    .c2h_capture     (c2h_capture),
    .busy            (busy),
    .step_count      (step_count),
    .pkt_count       (pkt_count),
    .err_overrun     (err_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sample and drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive h2c_pkt_done for one cycle; returns in the first cycle after it.
  task automatic pulse_pkt();
    h2c_pkt_done = 1'b1;
    tick();
    h2c_pkt_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;

    rst_n = 1'b0; cfg_step_cycles = 16'd1; cfg_capture_en = 1'b1;
    h2c_pkt_done = 1'b0; c2h_done = 1'b0;
    #1;
    repeat (3) tick();
    check("rst_h2c_en", 32'(h2c_en), 32'd1);
    check("rst_dut_clk_en", 32'(dut_clk_en), 32'd0);
    check("rst_c2h_capture", 32'(c2h_capture), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_step_count", step_count, 32'd0);
    check("rst_pkt_count", pkt_count, 32'd0);
    check("rst_err_overrun", 32'(err_overrun), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Legacy step: N=1 with capture, pulse at t=10, c2h_done at t=20.
    cfg_step_cycles = 16'd1; cfg_capture_en = 1'b1;
    pulse_pkt();
    for (int c = 11; c <= 21; c++) begin
      check($sformatf("leg_clk_en_t%0d", c), 32'(dut_clk_en), 32'(c == 11));
      check($sformatf("leg_capture_t%0d", c), 32'(c2h_capture), 32'(c == 12));
      check($sformatf("leg_h2c_en_t%0d", c), 32'(h2c_en), 32'(c == 21));
      c2h_done = (c == 20);
      if (c < 21) tick();
    end
    c2h_done = 1'b0;
    check("leg_step_count", step_count, 32'd1);
    check("leg_pkt_count", pkt_count, 32'd1);

    // Multi-cycle step without capture; cfg changed to 3 mid-step.
    cfg_step_cycles = 16'd5; cfg_capture_en = 1'b0;
    pulse_pkt();
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("multi_clk_en_t%0d", c), 32'(dut_clk_en), 32'(c <= 5));
      check($sformatf("multi_capture_t%0d", c), 32'(c2h_capture), 32'd0);
      check($sformatf("multi_h2c_en_t%0d", c), 32'(h2c_en), 32'(c == 6));
      if (c == 2) cfg_step_cycles = 16'd3;
      if (c < 6) tick();
    end
    check("multi_step_count", step_count, 32'd6);
    check("multi_pkt_count", pkt_count, 32'd2);

    // Zero step length behaves as one cycle.
    cfg_step_cycles = 16'd0; cfg_capture_en = 1'b0;
    pulse_pkt();
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (dut_clk_en) n++;
      tick();
    end
    check("zero_enabled_cycles", 32'(n), 32'd1);
    check("zero_h2c_en", 32'(h2c_en), 32'd1);
    check("zero_step_count", step_count, 32'd7);

    // Maximum step length, followed by capture.
    cfg_step_cycles = 16'hFFFF; cfg_capture_en = 1'b1;
    pulse_pkt();
    n = 0;
    while (dut_clk_en && n < 70000) begin
      n++;
      tick();
    end
    check("max_enabled_cycles", 32'(n), 32'd65535);
    check("max_capture", 32'(c2h_capture), 32'd1);
    tick();
    check("max_wait_h2c_en", 32'(h2c_en), 32'd0);
    c2h_done = 1'b1;
    tick();
    c2h_done = 1'b0;
    check("max_h2c_en_after_done", 32'(h2c_en), 32'd1);
    check("max_step_count", step_count, 32'd65542);
    check("max_pkt_count", pkt_count, 32'd4);

    // Overrun during RUN and during WAIT_C2H.
    cfg_step_cycles = 16'd4; cfg_capture_en = 1'b1;
    pulse_pkt();
    n = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (dut_clk_en) n++;
      if (c2h_capture) begin
        seen = 1'b1;
        break;
      end
      h2c_pkt_done = (c == 2);
      tick();
    end
    h2c_pkt_done = 1'b0;
    check("ovr_capture_seen", 32'(seen), 32'd1);
    check("ovr_run_length", 32'(n), 32'd4);
    check("ovr_err_after_run", 32'(err_overrun), 32'd1);
    check("ovr_pkt_count_run", pkt_count, 32'd5);
    tick();
    pulse_pkt();
    check("ovr_wait_busy", 32'(busy), 32'd1);
    check("ovr_wait_h2c_en", 32'(h2c_en), 32'd0);
    check("ovr_pkt_count_wait", pkt_count, 32'd5);
    c2h_done = 1'b1;
    tick();
    c2h_done = 1'b0;
    check("ovr_h2c_en_after_done", 32'(h2c_en), 32'd1);
    check("ovr_step_count", step_count, 32'd65546);
    c2h_done = 1'b1;
    tick();
    c2h_done = 1'b0;
    tick();
    check("stray_done_busy", 32'(busy), 32'd0);
    check("stray_done_h2c_en", 32'(h2c_en), 32'd1);
    check("stray_done_clk_en", 32'(dut_clk_en), 32'd0);
    check("ovr_err_sticky", 32'(err_overrun), 32'd1);

    // Reset in RUN cycle 40 of a 100-cycle step.
    cfg_step_cycles = 16'd100; cfg_capture_en = 1'b1;
    pulse_pkt();
    repeat (39) tick();
    check("mid_rst_clk_en_before", 32'(dut_clk_en), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_clk_en", 32'(dut_clk_en), 32'd0);
    check("mid_rst_capture", 32'(c2h_capture), 32'd0);
    check("mid_rst_step_count", step_count, 32'd0);
    check("mid_rst_pkt_count", pkt_count, 32'd0);
    check("mid_rst_err_overrun", 32'(err_overrun), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c2h_capture || busy || dut_clk_en) seen = 1'b1;
    end
    check("mid_rst_quiet_after", 32'(seen), 32'd0);
    check("mid_rst_h2c_en", 32'(h2c_en), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dut_step_ctrl.md
# dut_step_ctrl

Sequencer for the QDMA test application that owns the DUT clock-enable and readback timing. It counts complete H2C packets and enables the gated DUT clock for a runtime-programmable number of cycles per packet. It then optionally triggers a C2H capture and holds off further H2C traffic until the C2H engine reports the readback done. It drives the BUFGCE CE input and the h2c/c2h control ports, and extends the fixed one-pulse-per-packet sequencing to multi-cycle steps, capture skipping, status counters and overrun detection.

## Interface
- CNT_WIDTH, 16: width of the step-cycle configuration and internal cycle counter.
- STAT_WIDTH, 32: width of the status counters.

- clk  in  1  AXI clock; all logic is on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_step_cycles  in  CNT_WIDTH  DUT cycles per packet. Sampled on an accepted h2c_pkt_done. A value of 0 is treated as 1.
- cfg_capture_en  in  1  1 = capture after each step; 0 = skip capture and return to IDLE. Sampled with cfg_step_cycles.
- h2c_pkt_done  in  1  one-cycle pulse from the H2C block: vip2dut is fully loaded.
- c2h_done  in  1  one-cycle pulse from the C2H block: the capture transfer and CMPT are finished.
- h2c_en  out  1  H2C may accept the next packet.
- dut_clk_en  out  1  registered CE for the DUT BUFGCE.
- c2h_capture  out  1  registered one-cycle pulse; the C2H block latches dut2vip.
- busy  out  1  the FSM is not in IDLE.
- step_count  out  STAT_WIDTH  total DUT clock cycles enabled since reset; wraps.
- pkt_count  out  STAT_WIDTH  accepted packets since reset; wraps.
- err_overrun  out  1  sticky; set when h2c_pkt_done arrives while the FSM is not in IDLE.

## Operation
- FSM states: IDLE, RUN, CAPT, WAIT_C2H.
- IDLE
  - h2c_en=1.
  - On h2c_pkt_done: latch N = max(cfg_step_cycles, 1) and the capture flag, load the cycle counter with N, increment pkt_count, go to RUN.
- RUN
  - dut_clk_en=1 and h2c_en=0.
  - Each cycle: cycle counter decrements and step_count increments.
  - When the counter reaches 1: go to CAPT if the capture flag is 1, else go to IDLE.
- CAPT
  - One cycle; c2h_capture=1 and dut_clk_en=0; go to WAIT_C2H.
- WAIT_C2H
  - Hold h2c_en=0 until c2h_done, then go to IDLE.
  - A c2h_done seen in any other state is ignored.
- Overrun
  - h2c_pkt_done outside IDLE sets err_overrun.
  - The packet is not counted and does not restart the step.
  - err_overrun clears only on reset.
- Outputs
  - dut_clk_en, c2h_capture and h2c_en are decoded from the registered state: no combinational path from any input.
- Counters
  - step_count and pkt_count wrap modulo 2^STAT_WIDTH without saturation.
  - The cycle counter is CNT_WIDTH bits, so the maximum step is 2^CNT_WIDTH−1 cycles.

## Timing
- Reset values
  - State = IDLE.
  - h2c_en=1; dut_clk_en=0; c2h_capture=0; busy=0.
  - step_count=0; pkt_count=0; err_overrun=0.
- Step latency
  - h2c_pkt_done in cycle t → dut_clk_en high in cycles t+1 … t+N.
  - With capture: c2h_capture in cycle t+N+1.
  - Without capture: h2c_en high again in cycle t+N+1.
- With N=1 and capture: dut_clk_en high in t+1 and c2h_capture in t+2. This is exactly the legacy single-step sequence.
- h2c_en goes low in cycle t+1, the first RUN cycle.
- c2h_done in cycle u (in WAIT_C2H) → h2c_en=1 in cycle u+1.
- Reset mid-operation
  - The FSM returns to IDLE on the next edge; dut_clk_en drops immediately and any pending capture is discarded.
  - Counters clear.
- Configuration changes during RUN have no effect until the next accepted packet.

## Test plan
- Reset: hold rst_n=0 for 3 cycles → h2c_en=1, dut_clk_en=0, all counters 0, err_overrun=0.
- Legacy step: cfg_step_cycles=1, cfg_capture_en=1, pulse h2c_pkt_done at t=10, c2h_done at t=20.
  - Required: dut_clk_en high only at t=11; c2h_capture at t=12.
  - Required: h2c_en low for t=11..20 and high at t=21; step_count=1, pkt_count=1.
- Multi-cycle step: cfg_step_cycles=5, cfg_capture_en=0, pkt_done at t=0.
  - Required: dut_clk_en high t=1..5; no c2h_capture; h2c_en=1 at t=6; step_count=5.
  - Then change cfg_step_cycles to 3 at t=2: the current step still runs 5 cycles.
- Zero and max: cfg_step_cycles=0 → exactly 1 enabled cycle. cfg_step_cycles=16'hFFFF → 65535 enabled cycles, then capture.
- Overrun: pulse h2c_pkt_done during RUN and again during WAIT_C2H.
  - Required: err_overrun=1 and stays set; pkt_count not incremented; step length unchanged.
  - Required: a stray c2h_done in IDLE causes no transition.
- Reset mid-RUN: cfg_step_cycles=100, assert rst_n=0 at RUN cycle 40.
  - Required: dut_clk_en=0 on the next edge; no c2h_capture follows; FSM in IDLE after release.
